// File: rtl/key_schedule.sv
// key_schedule: AES-128/192/256 key expansion streaming one 128-bit round key per handshake.
module key_schedule #(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [1:0]              key_len,
    input  logic [MAX_KEY_BITS-1:0] key_in,
    input  logic                    rk_ready,
    output logic                    rk_valid,
    output logic [127:0]            rk_data,
    output logic [3:0]              rk_round,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    typedef enum logic [1:0] {IDLE, EXPAND, DRAIN} state_t;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254, followed by the AES affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int k = 0; k < 7; k++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    state_t                  state, state_nx;
    logic [1:0]              kl;
    logic [MAX_KEY_BITS-1:0] key;
    logic [5:0]              i, last_i;
    logic [2:0]              j, nk_m1;
    logic [7:0]              rcon;
    logic [31:0]             win [8];
    logic [31:0]             acc [3];
    logic [31:0]             w_prev, w_old, sub_in, sub_out, temp, w_new;
    logic                    legal, launch, hs, stall, adv;

    assign nk_m1   = kl == 2'd0 ? 3'd3 : kl == 2'd1 ? 3'd5 : 3'd7;
    assign last_i  = kl == 2'd0 ? 6'd43 : kl == 2'd1 ? 6'd51 : 6'd59;
    assign legal   = key_len != 2'd3 && (MAX_KEY_BITS >= 256 || key_len == 2'd0 ||
                                         (MAX_KEY_BITS >= 192 && key_len == 2'd1));
    assign launch  = state == IDLE && start && legal;
    assign hs      = rk_valid && rk_ready;
    assign stall   = i[1:0] == 2'd3 && rk_valid && !rk_ready;
    assign adv     = state == EXPAND && !stall;
    assign w_prev  = win[0];
    assign w_old   = win[nk_m1];
    assign sub_in  = j == 3'd0 ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    assign sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    assign temp    = j == 3'd0 ? sub_out ^ {rcon, 24'h0} : (kl == 2'd2 && j == 3'd4) ? sub_out : w_prev;
    assign w_new   = i <= {3'b0, nk_m1} ? key[MAX_KEY_BITS-1 -: 32] : w_old ^ temp;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;

    always_comb
        state_nx = launch ? EXPAND : (adv && i == last_i) ? DRAIN : (state == DRAIN && hs) ? IDLE : state;

    always_comb
        busy = state != IDLE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kl       <= 2'd0;
            key      <= '0;
            i        <= 6'd0;
            j        <= 3'd0;
            rcon     <= 8'h01;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_round <= 4'd0;
            done     <= 1'b0;
            err      <= 1'b0;
            for (int k = 0; k < 8; k++) win[k] <= '0;
            for (int k = 0; k < 3; k++) acc[k] <= '0;
        end else begin
            done <= state == DRAIN && hs;
            err  <= state == IDLE && start && !legal;
            if (launch) begin
                kl   <= key_len;
                key  <= key_in;
                i    <= 6'd0;
                j    <= 3'd0;
                rcon <= 8'h01;
            end
            if (adv) begin
                i <= i + 6'd1;
                j <= j == nk_m1 ? 3'd0 : j + 3'd1;
                if (i <= {3'b0, nk_m1}) key <= key << 32;
                if (j == 3'd0 && i > {3'b0, nk_m1}) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                win[0] <= w_new;
                for (int k = 1; k < 8; k++) win[k] <= win[k-1];
                if (i[1:0] != 2'd3) acc[i[1:0]] <= w_new;
            end
            // A completed fourth word reloads the output even on a handshake edge, so no bubble
            if (adv && i[1:0] == 2'd3) begin
                rk_valid <= 1'b1;
                rk_data  <= {acc[0], acc[1], acc[2], w_new};
                rk_round <= i[5:2];
            end else if (hs) begin
                rk_valid <= 1'b0;
            end
        end
    end
endmodule
